// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA demo datapath (640x480 @ 60 Hz).
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  // Standard VGA uses negative sync pulses on both axes.
  localparam int SYNC_ACTIVE_LOW_DEF = 1;
  localparam int FRAME_W_DEF         = 8;

  // Total period of one axis, in pixels or lines.
  function automatic int calc_total(input int disp, input int front,
                                    input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  function automatic int calc_h_total_def();
    return calc_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  endfunction

  function automatic int calc_v_total_def();
    return calc_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N position counter for one raster axis. Exposes the wrap strobe and
// the display/sync window flags of the value the counter will hold after
// this edge, so the parent can register them aligned with the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int N          = 800,
  parameter int DISP_END   = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_count,
  output logic               o_wrap,
  output logic               o_next_disp,
  output logic               o_next_sync
);

  localparam int          LAST_I       = N - 1;
  localparam logic [COORD_W-1:0] LAST  = LAST_I[COORD_W-1:0];
  localparam logic [COORD_W:0] DISP_END_W   = DISP_END[COORD_W:0];
  localparam logic [COORD_W:0] SYNC_START_W = SYNC_START[COORD_W:0];
  localparam logic [COORD_W:0] SYNC_END_W   = SYNC_END[COORD_W:0];

  logic [COORD_W-1:0] r_count;
  logic [COORD_W-1:0] w_next;
  logic               w_at_last;

  // Next count: step or wrap when enabled, otherwise hold.
  always_comb begin
    w_at_last = (r_count == LAST);
    w_next    = r_count;
    if (i_en) begin
      w_next = w_at_last ? '0 : r_count + 1'b1;
    end
  end

  // Count register; reset restarts the axis at position 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count     = r_count;
  assign o_wrap      = i_en & w_at_last;
  assign o_next_disp = ({1'b0, w_next} < DISP_END_W);
  assign o_next_sync = ({1'b0, w_next} >= SYNC_START_W) &&
                       ({1'b0, w_next} <  SYNC_END_W);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel coordinates, sync pulses, display window,
// line/frame strobes and a completed-frame counter, all stepped by i_pix_en.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter int SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF,
  parameter int FRAME_W         = FRAME_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pix_en,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_display_on,
  output logic               o_line_tick,
  output logic               o_frame_tick,
  output logic [FRAME_W-1:0] o_frame_count
);

  localparam int H_TOTAL = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  // Sync level outside the pulse; XOR with the in-window flag gives the pin.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL %0d exceeds coordinate range", H_TOTAL);
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL %0d exceeds coordinate range", V_TOTAL);
  end

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_v_en;
  logic w_frame_wrap;
  logic w_h_next_disp;
  logic w_h_next_sync;
  logic w_v_next_disp;
  logic w_v_next_sync;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_display_on;
  logic               r_line_tick;
  logic               r_frame_tick;
  logic [FRAME_W-1:0] r_frame_count;

  vga_axis_counter #(
    .N          (H_TOTAL),
    .DISP_END   (H_DISPLAY),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC)
  ) u_h_counter (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (i_pix_en),
    .o_count     (o_x),
    .o_wrap      (w_h_wrap),
    .o_next_disp (w_h_next_disp),
    .o_next_sync (w_h_next_sync)
  );

  // The line counter advances only on the pixel step that ends a line.
  assign w_v_en = w_h_wrap & i_pix_en;

  vga_axis_counter #(
    .N          (V_TOTAL),
    .DISP_END   (V_DISPLAY),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC)
  ) u_v_counter (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (w_v_en),
    .o_count     (o_y),
    .o_wrap      (w_v_wrap),
    .o_next_disp (w_v_next_disp),
    .o_next_sync (w_v_next_sync)
  );

  assign w_frame_wrap = w_h_wrap & w_v_wrap;

  // Registered outputs, derived from next-state flags so they line up with
  // the x/y presented in the same cycle. With i_pix_en low the next-state
  // flags equal the current ones, so these hold and the ticks drop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hsync       <= SYNC_IDLE;
      r_vsync       <= SYNC_IDLE;
      r_display_on  <= 1'b1;
      r_line_tick   <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hsync      <= w_h_next_sync ^ SYNC_IDLE;
      r_vsync      <= w_v_next_sync ^ SYNC_IDLE;
      r_display_on <= w_h_next_disp & w_v_next_disp;
      r_line_tick  <= w_h_wrap;
      r_frame_tick <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_display_on  = r_display_on;
  assign o_line_tick   = r_line_tick;
  assign o_frame_tick  = r_frame_tick;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, shrunk timing,
// shrunk timing with active-high sync) share one stimulus stream and are
// compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] d_x, d_y, s_x, s_y, p_x, p_y;
  logic d_hs, d_vs, d_disp, d_lt, d_ft;
  logic s_hs, s_vs, s_disp, s_lt, s_ft;
  logic p_hs, p_vs, p_disp, p_lt, p_ft;
  logic [7:0] d_fc, s_fc, p_fc;

  vga_timing_gen u_dut_def (
    .i_clk(clk), .i_reset(i_reset), .i_pix_en(i_pix_en),
    .o_x(d_x), .o_y(d_y), .o_hsync(d_hs), .o_vsync(d_vs),
    .o_display_on(d_disp), .o_line_tick(d_lt), .o_frame_tick(d_ft),
    .o_frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_dut_sml (
    .i_clk(clk), .i_reset(i_reset), .i_pix_en(i_pix_en),
    .o_x(s_x), .o_y(s_y), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_display_on(s_disp), .o_line_tick(s_lt), .o_frame_tick(s_ft),
    .o_frame_count(s_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_LOW(0)
  ) u_dut_pol (
    .i_clk(clk), .i_reset(i_reset), .i_pix_en(i_pix_en),
    .o_x(p_x), .o_y(p_y), .o_hsync(p_hs), .o_vsync(p_vs),
    .o_display_on(p_disp), .o_line_tick(p_lt), .o_frame_tick(p_ft),
    .o_frame_count(p_fc)
  );

  int n_pass = 0;
  int n_total = 0;
  int k = 0;          // enabled pixel steps since the last reset
  bit stepped = 1'b0; // the last edge advanced the raster

  typedef struct {
    bit rst;
    bit en;
    int exp_x;
    bit exp_lt;
  } vec_t;

  vec_t vecs[4];

  // Raster state after k enabled steps: x = k mod H_TOTAL, and so on.
  function automatic logic [32:0] model(int hd, int hf, int hs, int hb,
                                        int vd, int vf, int vs, int vb,
                                        bit sal, int steps, bit adv);
    int ht, vt, x, y, f;
    bit ha, va, lt;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    x = steps % ht;
    y = (steps / ht) % vt;
    f = (steps / (ht * vt)) % 256;
    ha = (x >= hd + hf) && (x < hd + hf + hs);
    va = (y >= vd + vf) && (y < vd + vf + vs);
    lt = adv && (x == 0);
    return {x[9:0], y[9:0], sal ? !ha : ha, sal ? !va : va,
            (x < hd) && (y < vd), lt, lt && (y == 0), f[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, k);
  endtask

  task automatic step(input bit r, input bit e);
    i_reset = r;
    i_pix_en = e;
    @(posedge clk);
    if (r) begin
      k = 0;
      stepped = 1'b0;
    end else if (e) begin
      k++;
      stepped = 1'b1;
    end else begin
      stepped = 1'b0;
    end
    #1;
    check("model_def", {d_x, d_y, d_hs, d_vs, d_disp, d_lt, d_ft, d_fc},
          model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, k, stepped));
    check("model_sml", {s_x, s_y, s_hs, s_vs, s_disp, s_lt, s_ft, s_fc},
          model(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, k, stepped));
    check("model_pol", {p_x, p_y, p_hs, p_vs, p_disp, p_lt, p_ft, p_fc},
          model(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, k, stepped));
  endtask

  initial begin
    int hs_low, disp_hi, n_adv, ft_cnt, vs_low;
    bit saw_wrap;
    logic [7:0] prev_fc;

    vecs[0] = '{rst: 1'b0, en: 1'b1, exp_x: 799, exp_lt: 1'b0};
    vecs[1] = '{rst: 1'b0, en: 1'b0, exp_x: 799, exp_lt: 1'b0};
    vecs[2] = '{rst: 1'b0, en: 1'b0, exp_x: 799, exp_lt: 1'b0};
    vecs[3] = '{rst: 1'b0, en: 1'b1, exp_x: 0,   exp_lt: 1'b1};

    // Reset state
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("rst_x", d_x, 0);
    check("rst_y", d_y, 0);
    check("rst_syncs", {d_hs, d_vs}, 2'b11);
    check("rst_disp_ticks", {d_disp, d_lt, d_ft}, 3'b100);
    check("rst_fc", d_fc, 0);
    check("rst_pol_syncs", {p_hs, p_vs}, 2'b00);

    // One full line
    hs_low = 0;
    disp_hi = 0;
    for (int i = 0; i < 800; i++) begin
      step(1'b0, 1'b1);
      if (d_hs == 1'b0) hs_low++;
      if (d_disp) disp_hi++;
    end
    check("line_hs_low_cycles", hs_low, 96);
    check("line_disp_cycles", disp_hi, 640);
    check("line_end_xy_tick", {d_x, d_y, d_lt}, {10'd0, 10'd1, 1'b1});

    // Random pix_en
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, $urandom_range(0, 3) != 0);
    end

    // Hold across a line wrap, starting at x=798
    n_adv = (798 - (k % 800) + 800) % 800;
    for (int i = 0; i < n_adv; i++) step(1'b0, 1'b1);
    check("pre_tbl_x", d_x, 798);
    for (int i = 0; i < 4; i++) begin
      step(vecs[i].rst, vecs[i].en);
      check("tbl_x", d_x, vecs[i].exp_x);
      check("tbl_line_tick", d_lt, vecs[i].exp_lt);
    end

    // Reset mid-line inside the hsync pulse
    n_adv = (700 - (k % 800) + 800) % 800;
    for (int i = 0; i < n_adv; i++) step(1'b0, 1'b1);
    check("pre_rst_hsync", {d_x, d_hs}, {10'd700, 1'b0});
    step(1'b1, 1'b1);
    check("midrst_state", {d_x, d_y, d_hs, d_vs, d_disp, d_lt, d_ft, d_fc},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

    // 256 shrunk frames: frame_count wraps back to 0
    ft_cnt = 0;
    vs_low = 0;
    saw_wrap = 1'b0;
    prev_fc = s_fc;
    for (int i = 0; i < 256 * 84; i++) begin
      step(1'b0, 1'b1);
      if (s_ft) ft_cnt++;
      if (s_vs == 1'b0) vs_low++;
      if (prev_fc == 8'd255 && s_fc == 8'd0) saw_wrap = 1'b1;
      prev_fc = s_fc;
    end
    check("sml_frame_ticks", ft_cnt, 256);
    check("sml_vsync_low_cycles", vs_low, 256 * 12);
    check("sml_fc_wrap_seen", saw_wrap, 1'b1);
    check("sml_fc_final", s_fc, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
